// File: rtl/inst_mem_loader_if.sv
// Load and fetch port bundle for inst_mem_loader.
// The slave modport is the memory side; the master is the loader/fetch driver.
interface inst_mem_loader_if #(
  parameter int IW = 9,
  parameter int AW = 12
);
  logic          LoadStart;
  logic [AW:0]   LoadLen;
  logic          LoadValid;
  logic [IW-1:0] LoadData;
  logic          LoadReady;
  logic          LoadDone;
  logic          LoadErr;
  logic          Busy;
  logic          InstReq;
  logic [AW-1:0] InstAddress;
  logic [IW-1:0] InstOut;
  logic          InstValid;

  modport slave (
    input  LoadStart, LoadLen, LoadValid, LoadData, InstReq, InstAddress,
    output LoadReady, LoadDone, LoadErr, Busy, InstOut, InstValid
  );

  modport master (
    output LoadStart, LoadLen, LoadValid, LoadData, InstReq, InstAddress,
    input  LoadReady, LoadDone, LoadErr, Busy, InstOut, InstValid
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Run-time loadable instruction memory: streams a program in, pads the tail
// with NOPs, then serves fetches through one registered block-RAM read.
module inst_mem_loader #(
  parameter int            IW       = 9,
  parameter int            AW       = 12,
  parameter logic [IW-1:0] NOP_WORD = 9'b010000010
) (
  input  logic             Clk,
  input  logic             Reset_n,
  inst_mem_loader_if.slave bus
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          ivld_q, ivld_d;
  logic [IW-1:0] rdata_q;
  logic          we;
  logic [IW-1:0] wdata;
  logic          rd_en;
  logic          len_err;

  logic [IW-1:0] mem [DEPTH];

  assign len_err = (bus.LoadLen > FULL);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
    wdata   = bus.LoadData;
    rd_en   = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        // A fetch issued together with LoadStart still completes on old data.
        rd_en = (state_q == RUN) && bus.InstReq;
        if (bus.LoadStart) begin
          wp_d    = '0;
          err_d   = len_err;
          cnt_d   = len_err ? FULL : bus.LoadLen;
          state_d = (cnt_d != '0) ? LOAD : PAD;
        end
      end
      LOAD: begin
        if (bus.LoadValid) begin
          we    = 1'b1;
          wp_d  = wp_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == (AW+1)'(1)) begin
            if (wp_d == FULL) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        we    = 1'b1;
        wdata = NOP_WORD;
        wp_d  = wp_q + 1'b1;
        if (wp_d == FULL) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ivld_d = rd_en;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ivld_q  <= ivld_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge Clk) begin
    if (we)    mem[wp_q[AW-1:0]] <= wdata;
    if (rd_en) rdata_q           <= mem[bus.InstAddress];
  end

  assign bus.LoadReady = (state_q == LOAD);
  assign bus.Busy      = (state_q == LOAD) || (state_q == PAD);
  assign bus.LoadDone  = done_q;
  assign bus.LoadErr   = err_q;
  assign bus.InstValid = ivld_q;
  assign bus.InstOut   = ivld_q ? rdata_q : NOP_WORD;

endmodule
